fpu_fp32_acc: RTL
=================

Name: fpu_fp32_acc

Overview:
- FP32 accumulate stage directly downstream of the FP32 multiplier; consumes product words and sums them into an internal accumulator (dot-product / MAC reduction).
- Numeric conventions match the multiplier:
  - denormals flush to zero;
  - truncation, no rounding (unless the optional feature is compiled in);
  - exponent overflow produces signed infinity;
  - exponent underflow produces zero.
- Multi-cycle FSM: one add in flight at a time; result is presented on a one-cycle valid pulse at the end of a sequence.

Parameters:
GUARD_BITS, 3, extra low-order bits kept below the 24-bit significand during align/add (guard, round, sticky); minimum 3.

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_data/in_clr/in_last are valid this cycle
in_ready  out  1  block can accept an operand this cycle
in_data  in  32  FP32 operand (multiplier product)
in_clr  in  1  treat accumulator as +0 for this operand (starts a new sum)
in_last  in  1  final operand of the sequence; publish the result
out_valid  out  1  one-cycle pulse, out_data holds the finished sum
out_data  out  32  FP32 sum, held until the next out_valid
acc_q  out  32  current accumulator value (debug/bypass)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous, active-high, named reset.
  - Reset values: state=IDLE, acc_q=0, out_data=0, out_valid=0, in_ready=1.
- Handshake:
  - An operand is accepted when in_valid && in_ready.
  - in_ready=1 only in IDLE.
  - in_clr and in_last are sampled with in_data.
- FSM states and transitions:
  - IDLE → ALIGN on accept.
  - ALIGN → NORM unconditionally.
  - NORM → IDLE unconditionally.
  - Throughput is one operand per 3 cycles.
- Latency:
  - Operand accepted in cycle T.
  - acc_q is updated at the clock edge ending cycle T+2 (NORM).
  - If in_last was set, out_valid=1 in cycle T+3, with out_data = new acc_q.
  - An accept in cycle T+3 is legal; out_valid and in_ready may be high together.
- Unpack:
  - Exponent 0 → operand is zero (sign kept, mantissa dropped).
  - Exponent 255 → infinity (mantissa ignored).
  - Otherwise significand = {1, frac[22:0]}.
- ALIGN cycle:
  - Order the operands by magnitude (exp, then frac); larger = A.
  - Shift B right by expA-expB into a 24+GUARD_BITS field; OR shifted-out bits into the LSB (sticky).
  - Difference ≥ 24+GUARD_BITS → B contributes sticky only.
  - Operand A is in_data and acc_q (or +0 when in_clr), whichever is larger.
- NORM cycle:
  - Add or subtract in a 25+GUARD_BITS field per the sign relation; result sign = sign of A.
  - Carry-out → shift right 1, exp+1.
  - Otherwise shift left by the leading-zero count, exp−count.
  - Exact-zero magnitude → +0 (0x00000000).
  - Final exp ≥ 255 → {sign, 0x7F800000}.
  - Final exp ≤ 0 → +0.
  - Guard bits are truncated.
- Infinity handling:
  - inf + finite → that inf.
  - Equal-sign infs → inf.
  - Opposite-sign infs → 0x7FC00000.
- in_clr && in_last on the same operand: result is the unpacked/flushed operand itself.
- Reset during ALIGN/NORM: the operation is discarded, acc_q=0, no out_valid.
- in_valid while in_ready=0: ignored; the upstream producer holds its data.

Optional Feature:
FPU_FP32_ACC_ROUND_EN:
- Defined: NORM rounds to nearest-even using guard/round/sticky. A mantissa carry from rounding increments exp and re-checks overflow to infinity. Latency is unchanged.
- Undefined: truncation; guard bits are discarded.

Decomposition:
- Package fpu_fp32_pkg:
  - FP32_EXP_BIAS=127, FP32_EXP_MAX=255;
  - FP32_INF=32'h7F800000, FP32_QNAN=32'h7FC00000;
  - field-width localparams (EXP_W=8, FRAC_W=23);
  - FSM state typedef {IDLE, ALIGN, NORM};
  - unpacked-operand struct (sgn, exp, sig, is_zero, is_inf).
- Sub-module fpu_fp32_lzc: combinational leading-zero counter over the 25+GUARD_BITS sum, instantiated in NORM.

Test Plan:
- 0x3F800000 (clr) then 0x40000000 (last) → out_valid 3 cycles after the second accept, out_data=0x40400000; in_ready low for exactly 2 cycles after each accept.
- 0x3F800000 (clr+last) then 0xBF800000 (clr+last) → first out 0x3F800000; with accumulation of 1.0 + -1.0 the sum is 0x00000000 (positive zero).
- 0x7F7FFFFF (clr) + 0x7F7FFFFF (last) → 0x7F800000; 0x7F800000 + 0xFF800000 → 0x7FC00000.
- 0x3F800000 (clr) + 0x33C00000 (last) → 0x3F800000 without the macro; 0x3F800001 with FPU_FP32_ACC_ROUND_EN.
- Denormal 0x00000001 (clr+last) → out_data=0x00000000; 0x00000001 added to 0x3F800000 → 0x3F800000.
- Accept 0x40000000 (clr+last), assert reset during NORM → no out_valid, acc_q=0, in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/fpu_fp32_pkg.sv
// Shared definitions for the FP32 accumulate stage: field widths, special
// encodings, the FSM state type and the unpacked-operand record.
package fpu_fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = FRAC_W + 1;

    localparam int FP32_EXP_BIAS = 127;
    localparam int FP32_EXP_MAX  = 255;

    localparam logic [31:0] FP32_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        NORM  = 2'd2
    } acc_state_t;

    typedef struct packed {
        logic               sgn;
        logic [EXP_W-1:0]   exp;
        logic [SIG_W-1:0]   sig;
        logic               is_zero;
        logic               is_inf;
    } fp32_unp_t;

    // Denormals flush to zero (sign kept); exponent 255 is infinity whatever
    // the mantissa holds; normals get their hidden bit.
    function automatic fp32_unp_t fp32_unpack(input logic [31:0] w);
        fp32_unp_t u;
        u.sgn = w[31];
        u.exp = w[30:23];
        if (w[30:23] == 8'd0) begin
            u.sig     = {SIG_W{1'b0}};
            u.is_zero = 1'b1;
            u.is_inf  = 1'b0;
        end else if (w[30:23] == 8'hFF) begin
            u.sig     = {1'b1, {FRAC_W{1'b0}}};
            u.is_zero = 1'b0;
            u.is_inf  = 1'b1;
        end else begin
            u.sig     = {1'b1, w[22:0]};
            u.is_zero = 1'b0;
            u.is_inf  = 1'b0;
        end
        return u;
    endfunction

endpackage

// File: rtl/fpu_fp32_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fpu_fp32_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/fpu_fp32_acc.sv
// FP32 accumulate stage behind the FP32 multiplier. Three-cycle FSM
// (IDLE accept, ALIGN, NORM), flush-to-zero, truncating by default.
// Build option: define FPU_FP32_ACC_ROUND_EN for round-to-nearest-even.
module fpu_fp32_acc
    import fpu_fp32_pkg::*;
#(
    parameter int GUARD_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_clr,
    input  logic        in_last,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] acc_q
);

    localparam int AW   = SIG_W + GUARD_BITS;   // aligned operand field
    localparam int SW   = AW + 1;               // sum field incl. carry
    localparam int LZ_W = $clog2(SW + 1);

    acc_state_t       state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [31:0]      out_data_r;
    logic [31:0]      acc_r;

    fp32_unp_t        op_r;
    logic             clr_r;
    logic             last_r;

    logic             a_sgn_r;
    logic [EXP_W-1:0] a_exp_r;
    logic [AW-1:0]    a_sig_r;
    logic [AW-1:0]    b_sig_r;
    logic             sub_r;
    logic             special_r;
    logic [31:0]      special_val_r;

    logic             accept_s;
    fp32_unp_t        acc_u_s;
    fp32_unp_t        a_s;
    fp32_unp_t        b_s;
    logic [EXP_W-1:0] d_s;
    logic [AW-1:0]    b_ext_s;
    logic [AW-1:0]    b_al_s;
    logic             special_s;
    logic [31:0]      special_val_s;

    logic [SW-1:0]       sum_s;
    logic [LZ_W-1:0]     lz_s;
    logic [SW-1:0]       norm_s;
    logic signed [9:0]   exp_s;
    logic [FRAC_W-1:0]   mant_s;
    logic signed [9:0]   exp_fin_s;
    logic [FRAC_W-1:0]   mant_fin_s;
    logic [31:0]         result_s;

    assign accept_s  = in_valid && in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign acc_q     = acc_r;

    // ALIGN: order operands by magnitude and shift the smaller one into place.
    always_comb begin
        acc_u_s       = fp32_unpack(acc_r);
        a_s           = op_r;
        b_s           = acc_u_s;
        b_al_s        = {AW{1'b0}};
        special_s     = 1'b0;
        special_val_s = 32'd0;
        if (clr_r) begin
            acc_u_s = fp32_unpack(32'd0);
        end else begin
            acc_u_s = acc_u_s;
        end
        if ({op_r.exp, op_r.sig} >= {acc_u_s.exp, acc_u_s.sig}) begin
            a_s = op_r;
            b_s = acc_u_s;
        end else begin
            a_s = acc_u_s;
            b_s = op_r;
        end
        d_s     = a_s.exp - b_s.exp;
        b_ext_s = {b_s.sig, {GUARD_BITS{1'b0}}};
        if (b_s.is_zero) begin
            b_al_s = {AW{1'b0}};
        end else if (32'(d_s) >= AW) begin
            b_al_s = {{(AW-1){1'b0}}, 1'b1};
        end else begin
            b_al_s = (b_ext_s >> d_s)
                   | {{(AW-1){1'b0}}, |(b_ext_s & ~({AW{1'b1}} << d_s))};
        end
        // Infinity always sorts as A, so only A needs testing here.
        if (a_s.is_inf) begin
            special_s = 1'b1;
            if (b_s.is_inf && (a_s.sgn != b_s.sgn)) begin
                special_val_s = FP32_QNAN;
            end else begin
                special_val_s = {a_s.sgn, FP32_INF[30:0]};
            end
        end else begin
            special_s     = 1'b0;
            special_val_s = 32'd0;
        end
    end

    // NORM: add/subtract the aligned significands.
    always_comb begin
        if (sub_r) begin
            sum_s = {1'b0, a_sig_r} - {1'b0, b_sig_r};
        end else begin
            sum_s = {1'b0, a_sig_r} + {1'b0, b_sig_r};
        end
    end

    fpu_fp32_lzc #(
        .WIDTH (SW),
        .CNT_W (LZ_W)
    ) u_lzc (
        .value (sum_s),
        .count (lz_s)
    );

    // The hidden bit is normalised to the carry position: a carry-out needs
    // no shift (exp+1), otherwise the left shift by lz reduces the exponent.
    always_comb begin
        norm_s = sum_s << lz_s;
        exp_s  = $signed({2'b00, a_exp_r}) + 10'sd1
               - $signed({{(10-LZ_W){1'b0}}, lz_s});
        mant_s = norm_s[SW-2 -: FRAC_W];
    end

`ifdef FPU_FP32_ACC_ROUND_EN
    logic              guard_s;
    logic              sticky_s;
    logic              round_up_s;
    logic [FRAC_W:0]   mant_rnd_s;

    // Round to nearest even; a mantissa wrap bumps the exponent.
    always_comb begin
        guard_s    = norm_s[SW-FRAC_W-2];
        sticky_s   = |norm_s[SW-FRAC_W-3:0];
        round_up_s = guard_s && (sticky_s || norm_s[SW-FRAC_W-1]);
        mant_rnd_s = {1'b0, mant_s} + {{FRAC_W{1'b0}}, round_up_s};
        if (mant_rnd_s[FRAC_W]) begin
            mant_fin_s = {FRAC_W{1'b0}};
            exp_fin_s  = exp_s + 10'sd1;
        end else begin
            mant_fin_s = mant_rnd_s[FRAC_W-1:0];
            exp_fin_s  = exp_s;
        end
    end
`else
    logic unused_guard_s;

    // Truncate: bits below the mantissa are dropped.
    always_comb begin
        unused_guard_s = ^norm_s[SW-FRAC_W-2:0];
        mant_fin_s     = mant_s;
        exp_fin_s      = exp_s;
    end
`endif

    // Final result selection: specials, exact zero, overflow, underflow.
    always_comb begin
        if (special_r) begin
            result_s = special_val_r;
        end else if (!norm_s[SW-1]) begin
            result_s = 32'd0;
        end else if (exp_fin_s >= $signed(10'(FP32_EXP_MAX))) begin
            result_s = {a_sgn_r, FP32_INF[30:0]};
        end else if (exp_fin_s <= 10'sd0) begin
            result_s = 32'd0;
        end else begin
            result_s = {a_sgn_r, exp_fin_s[7:0], mant_fin_s};
        end
    end

    // Control FSM with operand capture, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_data_r    <= 32'd0;
            acc_r         <= 32'd0;
            op_r          <= '0;
            clr_r         <= 1'b0;
            last_r        <= 1'b0;
            a_sgn_r       <= 1'b0;
            a_exp_r       <= {EXP_W{1'b0}};
            a_sig_r       <= {AW{1'b0}};
            b_sig_r       <= {AW{1'b0}};
            sub_r         <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (accept_s) begin
                        op_r       <= fp32_unpack(in_data);
                        clr_r      <= in_clr;
                        last_r     <= in_last;
                        in_ready_r <= 1'b0;
                        state_r    <= ALIGN;
                    end
                end
                ALIGN: begin
                    out_valid_r   <= 1'b0;
                    a_sgn_r       <= a_s.sgn;
                    a_exp_r       <= a_s.exp;
                    a_sig_r       <= {a_s.sig, {GUARD_BITS{1'b0}}};
                    b_sig_r       <= b_al_s;
                    sub_r         <= a_s.sgn ^ b_s.sgn;
                    special_r     <= special_s;
                    special_val_r <= special_val_s;
                    state_r       <= NORM;
                end
                NORM: begin
                    acc_r       <= result_s;
                    out_valid_r <= last_r;
                    if (last_r) begin
                        out_data_r <= result_s;
                    end
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
